// File: rtl/regbank_wb_queue.sv
// Write-back queue in front of the register bank write port, with a newest-pending-value lookup.
// Optional feature macro: WBQ_ZERO_DROP_EN (handshakes to register 0 complete without queuing).
module regbank_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_dr,
  input  logic [DW-1:0] in_data,
  input  logic          drain_en,
  output logic          write,
  output logic [AW-1:0] dr,
  output logic [DW-1:0] wrdata,
  input  logic [AW-1:0] lk_addr,
  output logic          lk_hit,
  output logic [DW-1:0] lk_data,
  output logic [CW-1:0] count
);

  logic [AW-1:0] mem_dr   [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic push, drop, alloc, pop;

  // Derived only from registered occupancy, so drain_en never reaches in_ready.
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;

`ifdef WBQ_ZERO_DROP_EN
  assign drop = (in_dr == '0);
`else
  assign drop = 1'b0;
`endif

  assign alloc = push && !drop;
  assign pop   = (count_q != '0) && drain_en;
  assign count = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(alloc) - CW'(pop);
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (alloc) begin
      tail_d = tail_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      write   <= 1'b0;
      dr      <= '0;
      wrdata  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      write   <= pop;
      if (pop) begin
        dr     <= mem_dr[head_q];
        wrdata <= mem_data[head_q];
      end
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (alloc) begin
      mem_dr[tail_q]   <= in_dr;
      mem_data[tail_q] <= in_data;
    end
  end

  // Scan oldest to newest so the last match (newest) wins; the output register is oldest of all.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    lk_hit  = 1'b0;
    lk_data = '0;
    if (write && (dr == lk_addr)) begin
      lk_hit  = 1'b1;
      lk_data = wrdata;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (mem_dr[idx] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = mem_data[idx];
      end
    end
`ifdef WBQ_ZERO_DROP_EN
    if (lk_addr == '0) begin
      lk_hit  = 1'b0;
      lk_data = '0;
    end
`endif
  end

endmodule

// File: doc/regbank_wb_queue.md
# regbank_wb_queue

Write-back queue placed directly upstream of the 32×32 register bank's single write port. It accepts destination/data pairs from the execute stage through a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It drains at most one entry per cycle onto the bank's `write`/`dr`/`wrdata` inputs. A combinational lookup port returns the newest pending value for a register, so operand reads made through `sr1`/`sr2` can be corrected before the bank is updated.

## Interface
- `DEPTH`, 4: number of FIFO entries; power of two, 2..16.
- `DW`, 32: data width; matches the bank's `wrdata` width.
- `AW`, 5: register address width; matches the bank's `dr`, `sr1` and `sr2` width.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: producer offers an entry.
- `in_ready` output 1: queue can accept an entry.
- `in_dr` input AW: destination register of the offered entry.
- `in_data` input DW: result value of the offered entry.
- `drain_en` input 1: permission to pop this cycle; 0 holds the queue, e.g. while the bank is in reset.
- `write` output 1: write strobe to the bank; registered.
- `dr` output AW: write address to the bank; registered.
- `wrdata` output DW: write data to the bank; registered.
- `lk_addr` input AW: register being read.
- `lk_hit` output 1: a pending write to `lk_addr` exists.
- `lk_data` output DW: newest pending value for `lk_addr`; 0 when there is no hit.
- `count` output $clog2(DEPTH+1): number of occupied entries; registered.

## Operation
- Storage: a circular FIFO of {dr, data} with head and tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH. `count` tracks occupancy.
- Push: occurs when `in_valid && in_ready`. The entry is written at tail, then tail and `count` increment.
- `in_ready` is derived from registered state only: `in_ready = (count != DEPTH)`.
  - A push into a full queue is never accepted, even when a pop happens in the same cycle.
  - No combinational path exists from `drain_en` to `in_ready`.
- Pop: occurs when `count != 0 && drain_en`. On that edge the head entry is loaded into the `dr`/`wrdata` output registers and `write` is set to 1; head increments and `count` decrements.
- When no pop occurs, `write` is cleared to 0. `dr` and `wrdata` hold their last values.
- Simultaneous push and pop on the same edge leaves `count` unchanged and moves both pointers.
- Ordering: strict FIFO. Entries with equal `dr` reach the bank in arrival order.
- Lookup (combinational):
  - Candidates are all occupied entries plus the output register when `write == 1`.
  - The newest match wins. Priority runs from tail−1 back to head, then the output register.
  - A `lk_hit == 1` result returns that candidate's data.
  - The entry being pushed this cycle is not visible to lookup.
- Reset, asynchronous while `reset` is 0:
  - `write=0`, `dr=0`, `wrdata=0`, `count=0`, head=tail=0.
  - `in_ready=1`, `lk_hit=0`, `lk_data=0`.
  - All pending entries are discarded. Reset asserted in mid-drain aborts the in-flight write immediately.

## Timing
- Push latency: an entry accepted at edge N can be popped at edge N+1. `write` is then high from N+1 to N+2, and the bank stores the value at edge N+2.
- Sustained throughput is one entry per cycle while `drain_en` stays 1 and pushes continue.
- The lookup path is purely combinational from `lk_addr` and the registered state.
- `count` and `in_ready` reflect the state after the most recent edge.

## Configuration
- `WBQ_ZERO_DROP_EN`:
  - Defined: a handshake with `in_dr == 0` completes (`in_ready` as normal) but allocates no entry; `count` and tail are unchanged. The lookup force-returns `lk_hit=0` when `lk_addr == 0`.
  - Undefined: register 0 is queued and looked up like any other register.

## Test plan
- Reset, then push (dr=3, data=30) at edge 1 with `drain_en=1` -> `count` = 1 after edge 1; `write=1`, `dr=3`, `wrdata=30` after edge 2; `count` = 0.
- With `drain_en=0`, push dr=1..4 with data 10,20,30,40 -> `count` = 4 and `in_ready=0`. A fifth push with `in_valid=1` is not accepted. Then raise `drain_en` -> writes to dr 1,2,3,4 appear in order on four consecutive cycles.
- Queue (5,50) then (5,55) with `drain_en=0`, set `lk_addr=5` -> `lk_hit=1`, `lk_data=55`; `lk_addr=6` -> `lk_hit=0`, `lk_data=0`.
- Full queue with `drain_en=1` and `in_valid=1` -> no push in the first cycle; pushes resume the next cycle. Over 40 cycles of DEPTH=4 wrap-around, all 32 data values 10·k arrive in order.
- Assert `reset` low mid-stream with `count` = 3 and `write=1` -> `write=0`, `count=0` and `in_ready=1` without waiting for a clock edge. After release, no stale write occurs.
- `WBQ_ZERO_DROP_EN` defined: push (0,99) -> handshake completes, `count` stays 0, no `write`; undefined: `write=1`, `dr=0`, `wrdata=99`.
